// File: rtl/fc_neuron_stream.sv
// Streaming fully-connected neuron: signed dot product of N_IN x/w pairs plus bias, saturated to OUT_W.
// Optional build macro FC_NEURON_RELU_EN applies ReLU to the saturated result.
module fc_neuron_stream #(
  parameter int N_IN  = 3136,
  parameter int DW    = 30,
  parameter int WW    = 9,
  parameter int OUT_W = 38
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WW-1:0]    b,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    x,
  input  logic signed [WW-1:0]    w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y,
  output logic                    busy,
  output logic                    sat
);

  localparam int ACC_W = DW + WW + $clog2(N_IN) + 1;
  localparam int PW    = DW + WW;
  // One bit of headroom for the bias add, wide enough to hold the OUT_W clip limits.
  localparam int CMP_W = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;
  localparam int CNT_W = $clog2(N_IN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_BIAS  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_IN - 1);

  localparam logic signed [CMP_W-1:0] Y_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] Y_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]               state;
  logic signed [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]         cnt;
  logic signed [WW-1:0]     bias_q;

  logic signed [PW-1:0]     x_ext;
  logic signed [PW-1:0]     w_ext;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [CMP_W-1:0]  sum;
  logic signed [OUT_W-1:0]  y_next;
  logic                     sat_next;

  // Operands are widened before the multiply so the full product is formed at PW bits.
  assign x_ext    = {{WW{x[DW-1]}}, x};
  assign w_ext    = {{DW{w[WW-1]}}, w};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign sum      = {{(CMP_W-ACC_W){acc[ACC_W-1]}}, acc} + {{(CMP_W-WW){bias_q[WW-1]}}, bias_q};

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    sat_next = 1'b0;
    y_next   = sum[OUT_W-1:0];
    if (sum > Y_MAX) begin
      y_next   = Y_MAX[OUT_W-1:0];
      sat_next = 1'b1;
    end else if (sum < Y_MIN) begin
      y_next   = Y_MIN[OUT_W-1:0];
      sat_next = 1'b1;
    end
`ifdef FC_NEURON_RELU_EN
    if (y_next[OUT_W-1]) y_next = '0;
`else
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      bias_q <= '0;
      y      <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            cnt    <= '0;
            bias_q <= b;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc <= acc + prod_ext;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_BEAT) state <= S_BIAS;
          end
        end
        S_BIAS: begin
          y     <= y_next;
          sat   <= sat_next;
          state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_fc_neuron_stream.sv
// Self-checking bench for fc_neuron_stream: two instances (N_IN=4 general, N_IN=2/OUT_W=8 clipping)
// checked against an integer reference model of dot product + bias + saturation.
module tb_fc_neuron_stream;

  localparam int A_DW = 12, A_WW = 8, A_OW = 16;
  localparam int C_DW = 10, C_WW = 8, C_OW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance a: N_IN=4
  logic                   a_start = 0, a_in_valid = 0, a_out_ready = 0;
  logic signed [A_WW-1:0] a_bias = '0, a_w = '0;
  logic signed [A_DW-1:0] a_x = '0;
  logic                   a_in_ready, a_out_valid, a_busy, a_sat;
  logic signed [A_OW-1:0] a_y;

  // Instance c: N_IN=2, narrow output for clipping
  logic                   c_start = 0, c_in_valid = 0, c_out_ready = 0;
  logic signed [C_WW-1:0] c_bias = '0, c_w = '0;
  logic signed [C_DW-1:0] c_x = '0;
  logic                   c_in_ready, c_out_valid, c_busy, c_sat;
  logic signed [C_OW-1:0] c_y;

  fc_neuron_stream #(.N_IN(4), .DW(A_DW), .WW(A_WW), .OUT_W(A_OW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .b(a_bias), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .x(a_x), .w(a_w), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .y(a_y), .busy(a_busy), .sat(a_sat));

  fc_neuron_stream #(.N_IN(2), .DW(C_DW), .WW(C_WW), .OUT_W(C_OW)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .b(c_bias), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .x(c_x), .w(c_w), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .y(c_y), .busy(c_busy), .sat(c_sat));

  int     n_checks = 0;
  int     n_errors = 0;
  longint a_sum;

  // Reference model: clip to the signed OUT_W range, then optional ReLU.
  function automatic longint exp_y(input longint v, input int ow);
    longint mx, mn, r;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    r  = (v > mx) ? mx : (v < mn) ? mn : v;
`ifdef FC_NEURON_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  function automatic bit exp_sat(input longint v, input int ow);
    longint mx;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    return (v > mx) || (v < -mx - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_begin(input int bias);
    a_start = 1'b1;
    a_bias  = bias[A_WW-1:0];
    tick();
    a_start = 1'b0;
    a_sum   = bias;
    n_checks++;
    if (a_busy !== 1'b1 || a_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL begin: busy=%b in_ready=%b, want 1/1", a_busy, a_in_ready);
    end
  endtask

  task automatic a_beat(input int xv, input int wv, input int gap);
    a_in_valid = 1'b0;
    repeat (gap) begin
      tick();
      n_checks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL stall: in_ready=%b out_valid=%b, want 1/0", a_in_ready, a_out_valid);
      end
    end
    a_in_valid = 1'b1;
    a_x = xv[A_DW-1:0];
    a_w = wv[A_WW-1:0];
    tick();
    a_in_valid = 1'b0;
    a_sum += longint'(xv) * longint'(wv);
  endtask

  task automatic a_finish(input string tag);
    longint ey;
    bit     es;
    ey = exp_y(a_sum, A_OW);
    es = exp_sat(a_sum, A_OW);
    n_checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL %s bias_cycle: in_ready=%b out_valid=%b busy=%b, want 0/0/1",
               tag, a_in_ready, a_out_valid, a_busy);
    end
    tick();
    n_checks++;
    if (a_out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s latency: out_valid=%b at 2nd edge after last beat, want 1", tag, a_out_valid);
    end
    n_checks++;
    if (longint'(a_y) !== ey || a_sat !== es) begin
      n_errors++;
      $display("FAIL %s result: y=%0d sat=%b, want y=%0d sat=%b", tag, a_y, a_sat, ey, es);
    end
  endtask

  task automatic a_release(input string tag);
    logic signed [A_OW-1:0] held;
    held = a_y;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_y !== held) begin
      n_errors++;
      $display("FAIL %s release: out_valid=%b busy=%b y=%0d, want 0/0/%0d",
               tag, a_out_valid, a_busy, a_y, held);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (a_y !== '0 || a_sat !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: y=%0d sat=%b ov=%b ir=%b busy=%b, want all 0",
               a_y, a_sat, a_out_valid, a_in_ready, a_busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (a_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_hold: busy=%b without start, want 0", a_busy);
    end
  endtask

  task automatic test_basic();
    a_begin(3);
    for (int i = 0; i < 4; i++) a_beat(i + 1, 1, 0);
    a_finish("basic");
    a_release("basic");
  endtask

  task automatic test_gaps();
    a_begin(3);
    for (int i = 0; i < 4; i++) a_beat(i + 1, 1, 3);
    a_finish("gaps");
    a_release("gaps");
  endtask

  task automatic test_neg_bias();
    a_begin(-20);
    for (int i = 0; i < 4; i++) a_beat(1, 1, 0);
    a_finish("neg_bias");
    a_release("neg_bias");
  endtask

  task automatic c_run(input int xv, input int wv, input int bias, input string tag);
    longint s, ey;
    bit     es;
    s  = longint'(bias) + 2 * longint'(xv) * longint'(wv);
    ey = exp_y(s, C_OW);
    es = exp_sat(s, C_OW);
    c_start = 1'b1;
    c_bias  = bias[C_WW-1:0];
    tick();
    c_start = 1'b0;
    c_in_valid = 1'b1;
    c_x = xv[C_DW-1:0];
    c_w = wv[C_WW-1:0];
    tick();
    tick();
    c_in_valid = 1'b0;
    tick();
    n_checks++;
    if (c_out_valid !== 1'b1 || longint'(c_y) !== ey || c_sat !== es) begin
      n_errors++;
      $display("FAIL %s: out_valid=%b y=%0d sat=%b, want 1 y=%0d sat=%b", tag, c_out_valid, c_y, c_sat, ey, es);
    end
    c_out_ready = 1'b1;
    tick();
    c_out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    c_run(100, 2, 0, "sat_pos");
    c_run(-100, 2, 0, "sat_neg");
    c_run(20, 2, 5, "sat_none");
  endtask

  task automatic test_reset_abort();
    a_begin(7);
    a_beat(9, 9, 0);
    a_beat(9, 9, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_busy !== 1'b0 || a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_accum: busy=%b in_ready=%b out_valid=%b, want 0", a_busy, a_in_ready, a_out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    a_begin(0);
    for (int i = 0; i < 4; i++) a_beat(5, 1, 0);
    a_finish("restart");
    // Abort while holding a result in OUT.
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_out_valid !== 1'b0 || a_y !== '0 || a_sat !== 1'b0 || a_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset_out: out_valid=%b y=%0d sat=%b busy=%b, want 0", a_out_valid, a_y, a_sat, a_busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_out_hold();
    logic signed [A_OW-1:0] held;
    a_begin(1);
    for (int i = 0; i < 4; i++) a_beat(2 * i - 3, 5, 0);
    a_finish("hold");
    held = a_y;
    for (int i = 0; i < 10; i++) begin
      a_start = i[0];
      tick();
      n_checks++;
      if (a_out_valid !== 1'b1 || a_y !== held || a_in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold cycle %0d: out_valid=%b y=%0d in_ready=%b, want 1 y=%0d 0", i, a_out_valid, a_y, a_in_ready, held);
      end
    end
    // start on the leaving edge must be ignored
    a_start = 1'b1;
    a_out_ready = 1'b1;
    tick();
    a_start = 1'b0;
    a_out_ready = 1'b0;
    tick();
    n_checks++;
    if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_y !== held) begin
      n_errors++;
      $display("FAIL leave_start: busy=%b out_valid=%b y=%0d, want 0 0 %0d", a_busy, a_out_valid, a_y, held);
    end
  endtask

  task automatic test_back_to_back();
    int xv, wv, bv, gap;
    for (int t = 0; t < 30; t++) begin
      bv = int'($urandom_range(0, 255)) - 128;
      a_begin(bv);
      for (int i = 0; i < 4; i++) begin
        if (t % 3 == 0) xv = int'($urandom_range(0, 63)) - 32;
        else            xv = int'($urandom_range(0, 4095)) - 2048;
        wv  = int'($urandom_range(0, 255)) - 128;
        gap = (t % 2 == 0) ? 0 : int'($urandom_range(0, 2));
        a_beat(xv, wv, gap);
      end
      a_finish("random");
      a_release("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_neg_bias();
    test_saturate();
    test_reset_abort();
    test_out_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
